register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL take parameter AWIDTH, default 5, address width; depth is 2**AWIDTH entries.
REQ-002 SHALL take parameter DWIDTH, default 32, data width.
REQ-003 SHALL take parameter NREAD, default 2, number of read ports, legal range 1-4.
REQ-004 SHALL take parameter NWRITE, default 2, number of write ports, legal range 1-2.
REQ-005 SHALL take parameter BYPASS, default 1; a value of 1 enables same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port raddr, input, NREAD x AWIDTH: read addresses.
REQ-009 SHALL have port rdata, output, NREAD x DWIDTH: read data, combinational from raddr.
REQ-010 SHALL have port rbusy, output, NREAD bits: addressed entry has a pending producer.
REQ-011 SHALL have port wen, input, NWRITE bits: write enables.
REQ-012 SHALL have port waddr, input, NWRITE x AWIDTH: write addresses.
REQ-013 SHALL have port wdata, input, NWRITE x DWIDTH: write data.
REQ-014 SHALL have port bset_en, input, 1 bit: mark an entry busy.
REQ-015 SHALL have port bset_addr, input, AWIDTH bits: entry to mark busy.

Function
REQ-016 SHALL hold entry 0 at zero permanently: writes to address 0 are discarded, and reads of address 0 return 0 with rbusy 0.
REQ-017 SHALL update an entry on the rising clk edge when wen[i]=1 and waddr[i]!=0, storing wdata[i].
REQ-018 SHALL let the highest-index port win when two write ports target the same nonzero address in one cycle; the other write is dropped.
REQ-019 SHALL, with BYPASS=0, make rdata[j] equal the stored entry at raddr[j]; a same-cycle write becomes visible the cycle after.
REQ-020 SHALL, with BYPASS=1, forward wdata of the winning port (per REQ-018) to rdata[j] when any wen[i]=1 and waddr[i]==raddr[j]!=0.
REQ-021 SHALL keep one busy bit per entry; busy[0] is constantly 0.
REQ-022 SHALL set busy[bset_addr] on the clock edge when bset_en=1 and bset_addr!=0.
REQ-023 SHALL clear busy[a] on the clock edge when any enabled write targets a!=0.
REQ-024 SHALL let a set win over a clear when set and clear target the same address in one cycle; the entry is busy afterward.
REQ-025 SHALL drive rbusy[j]=busy[raddr[j]]; with BYPASS=1, rbusy[j] is forced to 0 when a same-cycle write forwards per REQ-020.
REQ-026 SHALL allow all read ports to address the same entry simultaneously, each returning identical data and busy status.
REQ-027 SHALL leave stored data unchanged by busy set or clear; busy is status only.

Reset
REQ-028 SHALL clear all entries and all busy bits to 0 immediately on rst=1, independent of clk.
REQ-029 SHALL, during reset, ignore wen and bset_en; rdata and rbusy read 0 for every address.
REQ-030 SHALL, when reset asserts mid-cycle with writes pending, discard those writes; the first write taking effect is the first rising edge with rst=0.

Verification
REQ-031 SHALL cover this scenario: after reset, read all addresses -> rdata=0 and rbusy=0 everywhere.
REQ-032 SHALL cover this scenario: wen[0]=1, waddr[0]=0, wdata[0]=0xDEADBEEF, then read address 0 -> 0; also read address 0 in the same cycle with BYPASS=1 -> 0.
REQ-033 SHALL cover this scenario: wen=2'b11, both waddr=5, wdata[0]=0x11, wdata[1]=0x22 -> same-cycle rdata (BYPASS=1) is 0x22, and the next cycle reads 0x22.
REQ-034 SHALL cover this scenario: bset_en=1 at address 7 -> the next cycle rbusy=1 for raddr=7; then a write of 0x55 to 7 -> the same cycle rbusy=0 and rdata=0x55 (BYPASS=1), and the next cycle busy is cleared.
REQ-035 SHALL cover this scenario: bset_en=1 at address 9 in the same cycle as a write of 0x33 to 9 -> the entry holds 0x33 and busy[9]=1 afterward.
REQ-036 SHALL cover this scenario: load 0xAA into address 3, set busy at 3, assert rst asynchronously between edges -> rdata and rbusy for address 3 drop to 0 before the next edge.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with a hard-wired zero entry,
// per-entry busy (pending producer) tracking and optional write-to-read
// forwarding. Reads are combinational; all state updates on the rising clk edge.
module register_file_mp #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*AWIDTH-1:0]  raddr,
  output logic [NREAD*DWIDTH-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*AWIDTH-1:0] waddr,
  input  logic [NWRITE*DWIDTH-1:0] wdata,
  input  logic                     bset_en,
  input  logic [AWIDTH-1:0]        bset_addr
);

  localparam int DEPTH = 2**AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic [AWIDTH-1:0] wa [NWRITE];
  logic [DWIDTH-1:0] wd [NWRITE];
  logic              wv [NWRITE];

  // Unpack the write ports; a write to entry 0 is never valid.
  for (genvar i = 0; i < NWRITE; i++) begin : g_wunpack
    assign wa[i] = waddr[i*AWIDTH +: AWIDTH];
    assign wd[i] = wdata[i*DWIDTH +: DWIDTH];
    assign wv[i] = wen[i] && (wa[i] != '0);
  end

  // Data storage: later ports are assigned last, so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (wv[i]) begin
          mem[wa[i]] <= wd[i];
        end
      end
    end
  end

  // Busy next state: writes clear, then a set overrides a same-address clear.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWRITE; i++) begin
      if (wv[i]) begin
        busy_nxt[wa[i]] = 1'b0;
      end
    end
    if (bset_en && (bset_addr != '0)) begin
      busy_nxt[bset_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_read
    logic [AWIDTH-1:0] ra;
    logic [DWIDTH-1:0] rd;
    logic              rb;

    assign ra = raddr[j*AWIDTH +: AWIDTH];

    // Read mux with forwarding; ascending scan lets the highest write port win.
    // Forwarding is suppressed in reset so every read returns zero.
    always_comb begin
      rd = mem[ra];
      rb = busy[ra];
      if ((BYPASS == 1) && !rst && (ra != '0)) begin
        for (int i = 0; i < NWRITE; i++) begin
          if (wv[i] && (wa[i] == ra)) begin
            rd = wd[i];
            rb = 1'b0;
          end
        end
      end
    end

    assign rdata[j*DWIDTH +: DWIDTH] = rd;
    assign rbusy[j]                  = rb;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed scenarios plus randomized traffic against an
// array-based reference model of the register file (default parameters).
module tb_register_file_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             bset_en;
  logic [AW-1:0]    bset_addr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem  [DEPTH];
  logic          model_busy [DEPTH];

  register_file_mp #(
    .AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .bset_en(bset_en), .bset_addr(bset_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      model_mem[k]  = '0;
      model_busy[k] = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] get_waddr(input int p);
    return waddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] get_wdata(input int p);
    return wdata[p*DW +: DW];
  endfunction

  // Expected read: zero entry and reset read 0; the highest write port aimed at
  // the address is forwarded with busy 0; otherwise the stored value and status.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
    d = model_mem[a];
    b = model_busy[a];
    if (rst || a == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wen[i] && get_waddr(i) == a) begin
          d = get_wdata(i);
          b = 1'b0;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      for (int i = 0; i < NW; i++) begin
        if (wen[i] && get_waddr(i) != 0) begin
          model_mem[get_waddr(i)]  = get_wdata(i);
          model_busy[get_waddr(i)] = 1'b0;
        end
      end
      if (bset_en && bset_addr != 0) model_busy[bset_addr] = 1'b1;
    end
  endtask

  task automatic check_reads();
    logic [DW-1:0] d;
    logic          b;
    for (int j = 0; j < NR; j++) begin
      model_read(raddr[j*AW +: AW], d, b);
      check_val($sformatf("rdata%0d@%0d", j, raddr[j*AW +: AW]), 64'(rdata[j*DW +: DW]), 64'(d));
      check_val($sformatf("rbusy%0d@%0d", j, raddr[j*AW +: AW]), 64'(rbusy[j]), 64'(b));
    end
  endtask

  // Inputs are set at the negedge; sample 1 time unit later, then clock.
  task automatic step();
    #1;
    check_reads();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_w(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p] = en;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_r(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr[0 +: AW]  = a0;
    raddr[AW +: AW] = a1;
  endtask

  task automatic idle();
    wen = '0;
    waddr = '0;
    wdata = '0;
    bset_en = 1'b0;
    bset_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Everything reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      set_r(AW'(a), AW'(DEPTH - 1 - a));
      step();
    end

    // Writes to entry 0 are discarded, with or without forwarding.
    set_w(0, 1'b1, 5'd0, 32'hDEADBEEF);
    set_r(5'd0, 5'd0);
    #1;
    check_val("zero_same_cycle", 64'(rdata[0 +: DW]), 64'h0);
    step();
    idle();
    step();
    check_val("zero_after", 64'(rdata[0 +: DW]), 64'h0);

    // Same-address dual write: port 1 wins.
    set_w(0, 1'b1, 5'd5, 32'h11);
    set_w(1, 1'b1, 5'd5, 32'h22);
    set_r(5'd5, 5'd5);
    #1;
    check_val("dual_fwd", 64'(rdata[DW +: DW]), 64'h22);
    step();
    idle();
    #1;
    check_val("dual_stored", 64'(rdata[0 +: DW]), 64'h22);
    step();

    // Busy set, then cleared by a write that forwards with busy 0.
    bset_en = 1'b1;
    bset_addr = 5'd7;
    set_r(5'd7, 5'd7);
    step();
    idle();
    #1;
    check_val("busy_set7", 64'(rbusy), 64'b11);
    step();
    set_w(1, 1'b1, 5'd7, 32'h55);
    #1;
    check_val("busy_fwd7", 64'(rbusy), 64'b00);
    check_val("data_fwd7", 64'(rdata[0 +: DW]), 64'h55);
    step();
    idle();
    #1;
    check_val("busy_clr7", 64'(rbusy), 64'b00);
    step();

    // Set wins over same-cycle clear; data still written.
    bset_en = 1'b1;
    bset_addr = 5'd9;
    set_w(0, 1'b1, 5'd9, 32'h33);
    set_r(5'd9, 5'd0);
    step();
    idle();
    #1;
    check_val("set_win_data9", 64'(rdata[0 +: DW]), 64'h33);
    check_val("set_win_busy9", 64'(rbusy[0]), 64'h1);
    step();

    // Async reset between edges with writes pending.
    set_w(0, 1'b1, 5'd3, 32'hAA);
    bset_en = 1'b1;
    bset_addr = 5'd3;
    set_r(5'd3, 5'd3);
    step();
    idle();
    #1;
    check_val("pre_rst_data3", 64'(rdata[0 +: DW]), 64'hAA);
    check_val("pre_rst_busy3", 64'(rbusy[0]), 64'h1);
    set_w(0, 1'b1, 5'd3, 32'hBB);
    bset_en = 1'b1;
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    check_val("rst_async_data3", 64'(rdata[0 +: DW]), 64'h0);
    check_val("rst_async_busy3", 64'(rbusy[0]), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_reads();
    rst = 1'b0;
    idle();
    step();

    // Randomized traffic against the model, biased toward address collisions.
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NW; p++) begin
        set_w(p, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1)),
              DW'($urandom));
      end
      bset_en = 1'($urandom_range(0, 2) == 0);
      bset_addr = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
      set_r(AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1)),
            AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1)));
      if (n % 7 == 3) raddr[AW +: AW] = raddr[0 +: AW];
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
